// File: rtl/pipe_cpu_param.sv
// Parametrised 4-stage (IF/ID/EX/WB) in-order core with loadable imem, HALT and run/freeze control.
// Latency: the first instruction writes back after the 3rd edge; FORWARD_EN selects EX forwarding over a 1-cycle ID stall.
// Backpressure: run=0 freezes all pipeline/PC/regfile state; ID RAW hazards hold IF/ID and pc and insert a bubble.
module pipe_cpu_param #(
    parameter int DATA_W  = 8,
    parameter int REG_AW  = 3,
    parameter int IMEM_AW = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  imem_we,
    input  logic [IMEM_AW-1:0]    imem_addr,
    input  logic [4+3*REG_AW-1:0] imem_wdata,
    output logic [IMEM_AW-1:0]    pc_o,
    output logic                  wb_valid,
    output logic [REG_AW-1:0]     wb_rd,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  stall_o,
    output logic                  halted
);

    localparam int INSTR_W = 4 + 3*REG_AW;
    localparam int NREG    = 2**REG_AW;
    localparam int NIMEM   = 2**IMEM_AW;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_LDI  = 4'd6;
    localparam logic [3:0] OP_MOV  = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [REG_AW-1:0]  reg_t;
    typedef logic [INSTR_W-1:0] instr_t;

    function automatic logic writes_rd(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd7);
    endfunction

    function automatic logic uses_rs1(input logic [3:0] op);
        return ((op >= 4'd1) && (op <= 4'd5)) || (op == OP_MOV);
    endfunction

    function automatic logic uses_rs2(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    instr_t              imem [NIMEM];
    data_t               rf   [NREG];
    logic [IMEM_AW-1:0]  pc;
    logic                fetch_stop;
    logic                halted_q;

    logic                if_id_vld;
    instr_t              if_id_instr;

    logic                id_ex_vld;
    logic [3:0]          id_ex_op;
    reg_t                id_ex_rd;
    data_t               id_ex_a;
    data_t               id_ex_b;
    data_t               id_ex_imm;
`ifdef FORWARD_EN
    reg_t                id_ex_rs1;
    reg_t                id_ex_rs2;
`endif

    logic                ex_wb_vld;
    logic [3:0]          ex_wb_op;
    reg_t                ex_wb_rd;
    data_t               ex_wb_res;

    logic [3:0]          id_op;
    reg_t                id_rd;
    reg_t                id_rs1;
    reg_t                id_rs2;
    data_t               id_a;
    data_t               id_b;
    data_t               id_imm;
    logic                id_is_halt;
    logic                stall;
    data_t               ex_a;
    data_t               ex_b;
    data_t               ex_res;

    assign id_op      = if_id_instr[INSTR_W-1 -: 4];
    assign id_rd      = if_id_instr[3*REG_AW-1 -: REG_AW];
    assign id_rs1     = if_id_instr[2*REG_AW-1 -: REG_AW];
    assign id_rs2     = if_id_instr[REG_AW-1:0];
    assign id_imm     = data_t'({id_rs1, id_rs2});
    assign id_is_halt = if_id_vld && (id_op == OP_HALT);

    assign wb_valid = ex_wb_vld && writes_rd(ex_wb_op);
    assign wb_rd    = ex_wb_rd;
    assign wb_data  = ex_wb_res;
    assign pc_o     = pc;
    assign stall_o  = stall;
    assign halted   = halted_q;

    // Regfile write-through: the value retiring this cycle is visible to ID now.
    always_comb begin
        id_a = rf[id_rs1];
        id_b = rf[id_rs2];
        if (wb_valid && (wb_rd == id_rs1)) id_a = wb_data;
        if (wb_valid && (wb_rd == id_rs2)) id_b = wb_data;
    end

`ifdef FORWARD_EN
    assign stall = 1'b0;
`else
    assign stall = if_id_vld && id_ex_vld && writes_rd(id_ex_op) &&
                   ((uses_rs1(id_op) && (id_ex_rd == id_rs1)) ||
                    (uses_rs2(id_op) && (id_ex_rd == id_rs2)));
`endif

    always_comb begin
        ex_a = id_ex_a;
        ex_b = id_ex_b;
`ifdef FORWARD_EN
        if (wb_valid && (wb_rd == id_ex_rs1)) ex_a = wb_data;
        if (wb_valid && (wb_rd == id_ex_rs2)) ex_b = wb_data;
`endif
        ex_res = '0;
        case (id_ex_op)
            OP_ADD:  ex_res = ex_a + ex_b;
            OP_SUB:  ex_res = ex_a - ex_b;
            OP_AND:  ex_res = ex_a & ex_b;
            OP_OR:   ex_res = ex_a | ex_b;
            OP_XOR:  ex_res = ex_a ^ ex_b;
            OP_LDI:  ex_res = id_ex_imm;
            OP_MOV:  ex_res = ex_a;
            default: ex_res = '0;
        endcase
    end

    // Instruction memory is deliberately outside reset so the harness can load it while reset is held.
    always_ff @(posedge clk) begin
        if (imem_we) imem[imem_addr] <= imem_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= data_t'(i);
        end else if (run && wb_valid) begin
            rf[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= '0;
            fetch_stop  <= 1'b0;
            halted_q    <= 1'b0;
            if_id_vld   <= 1'b0;
            if_id_instr <= '0;
            id_ex_vld   <= 1'b0;
            id_ex_op    <= '0;
            id_ex_rd    <= '0;
            id_ex_a     <= '0;
            id_ex_b     <= '0;
            id_ex_imm   <= '0;
`ifdef FORWARD_EN
            id_ex_rs1   <= '0;
            id_ex_rs2   <= '0;
`endif
            ex_wb_vld   <= 1'b0;
            ex_wb_op    <= '0;
            ex_wb_rd    <= '0;
            ex_wb_res   <= '0;
        end else if (run) begin
            if (!stall) begin
                if (id_is_halt || fetch_stop) begin
                    if_id_vld <= 1'b0;
                end else begin
                    if_id_vld   <= 1'b1;
                    if_id_instr <= imem[pc];
                    pc          <= pc + 1'b1;
                end
            end
            if (id_is_halt) fetch_stop <= 1'b1;

            id_ex_vld <= if_id_vld && !stall;
            id_ex_op  <= id_op;
            id_ex_rd  <= id_rd;
            id_ex_a   <= id_a;
            id_ex_b   <= id_b;
            id_ex_imm <= id_imm;
`ifdef FORWARD_EN
            id_ex_rs1 <= id_rs1;
            id_ex_rs2 <= id_rs2;
`endif

            ex_wb_vld <= id_ex_vld;
            ex_wb_op  <= id_ex_op;
            ex_wb_rd  <= id_ex_rd;
            ex_wb_res <= ex_res;

            if (ex_wb_vld && (ex_wb_op == OP_HALT)) halted_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_cpu_param.sv
// Randomized and directed checks of pipe_cpu_param against an instruction-level reference model.
module tb_pipe_cpu_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [12:0] imem_wdata;
    logic [3:0]  pc_o;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [7:0]  wb_data;
    logic        stall_o;
    logic        halted;

    pipe_cpu_param #(.DATA_W(8), .REG_AW(3), .IMEM_AW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .pc_o       (pc_o),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .stall_o    (stall_o),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [12:0] prog [16];
    logic [10:0] exp_q [$];
    logic [10:0] obs_q [$];
    logic        exp_halt;
    int          exp_halt_pc;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [12:0] enc(input int op, input int rd, input int s1, input int s2);
        return {op[3:0], rd[2:0], s1[2:0], s2[2:0]};
    endfunction

    // Retirement monitor: a writeback visible while run=1 commits at the coming edge.
    always @(negedge clk) begin
        #1;
        if (!reset && run && wb_valid) obs_q.push_back({wb_rd, wb_data});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds reset while loading imem, then releases with run=1 on a falling edge.
    task automatic start_test();
        reset   = 1'b1;
        run     = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            imem_we    = 1'b1;
            imem_addr  = i[3:0];
            imem_wdata = prog[i];
        end
        @(negedge clk);
        imem_we = 1'b0;
        reset   = 1'b0;
        run     = 1'b1;
        obs_q.delete();
        exp_q.delete();
    endtask

    // Architectural reference: executes the program one instruction at a time from address 0.
    task automatic model_run(input int budget);
        logic [7:0]  r [8];
        logic [7:0]  v;
        logic [12:0] w;
        logic [3:0]  op;
        logic [2:0]  rd, s1, s2;
        logic        wr;
        int          pc;
        exp_halt    = 1'b0;
        exp_halt_pc = 0;
        for (int i = 0; i < 8; i++) r[i] = i[7:0];
        pc = 0;
        for (int n = 0; n < budget && !exp_halt; n++) begin
            w  = prog[pc];
            op = w[12:9]; rd = w[8:6]; s1 = w[5:3]; s2 = w[2:0];
            wr = 1'b1;
            v  = 8'd0;
            case (op)
                4'd1:    v = r[s1] + r[s2];
                4'd2:    v = r[s1] - r[s2];
                4'd3:    v = r[s1] & r[s2];
                4'd4:    v = r[s1] | r[s2];
                4'd5:    v = r[s1] ^ r[s2];
                4'd6:    v = {2'b00, s1, s2};
                4'd7:    v = r[s1];
                4'd15: begin
                    wr          = 1'b0;
                    exp_halt    = 1'b1;
                    exp_halt_pc = (pc + 1) % 16;
                end
                default: wr = 1'b0;
            endcase
            if (wr) begin
                r[rd] = v;
                exp_q.push_back({rd, v});
            end
            pc = (pc + 1) % 16;
        end
    endtask

    task automatic compare_stream(input string tag, input bit exact);
        int n;
        n = obs_q.size();
        if (exact) check({tag, "_count"}, n, exp_q.size());
        else       check({tag, "_count_ok"}, int'(n > 0 && n <= exp_q.size()), 1);
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            check({tag, "_rd"},   int'(obs_q[i][10:8]), int'(exp_q[i][10:8]));
            check({tag, "_data"}, int'(obs_q[i][7:0]),  int'(exp_q[i][7:0]));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc"},    int'(pc_o),     0);
        check({tag, "_wbv"},   int'(wb_valid), 0);
        check({tag, "_wbrd"},  int'(wb_rd),    0);
        check({tag, "_wbdat"}, int'(wb_data),  0);
        check({tag, "_stall"}, int'(stall_o),  0);
        check({tag, "_halt"},  int'(halted),   0);
    endtask

    int e_stall [6];
    int e_wbv   [6];
    int e_rd    [6];
    int e_data  [6];
    int act;
    int op;

    initial begin
        reset = 1'b0; run = 1'b0; imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;
        #1 reset = 1'b1;
        @(negedge clk);
        check_all_zero("reset_init");

        // ADD latency and write-through to a later MOV.
        for (int i = 0; i < 16; i++) prog[i] = '0;
        prog[0] = enc(1, 3, 1, 2);
        prog[3] = enc(7, 4, 3, 0);
        start_test();
        tick(2);
        check("add_wbv_edge2", int'(wb_valid), 0);
        tick(1);
        check("add_wbv_edge3", int'(wb_valid), 1);
        check("add_rd_edge3",  int'(wb_rd),    3);
        check("add_dat_edge3", int'(wb_data),  3);
        tick(8);
        run = 1'b0;
        tick(2);
        exp_q.push_back({3'd3, 8'd3});
        exp_q.push_back({3'd4, 8'd3});
        compare_stream("add", 1'b1);

        // Distance-1 RAW hazard timing.
`ifdef FORWARD_EN
        e_stall = '{0, 0, 0, 0, 0, 0};
        e_wbv   = '{0, 0, 1, 1, 0, 0};
        e_rd    = '{0, 0, 4, 5, 0, 0};
        e_data  = '{0, 0, 3, 2, 0, 0};
`else
        e_stall = '{0, 1, 0, 0, 0, 0};
        e_wbv   = '{0, 0, 1, 0, 1, 0};
        e_rd    = '{0, 0, 4, 0, 5, 0};
        e_data  = '{0, 0, 3, 0, 2, 0};
`endif
        for (int i = 0; i < 16; i++) prog[i] = '0;
        prog[0] = enc(1, 4, 1, 2);
        prog[1] = enc(2, 5, 4, 1);
        start_test();
        for (int t = 0; t < 6; t++) begin
            tick(1);
            check($sformatf("raw_stall_t%0d", t + 1), int'(stall_o), e_stall[t]);
            check($sformatf("raw_wbv_t%0d", t + 1),   int'(wb_valid), e_wbv[t]);
            if (e_wbv[t] != 0) begin
                check($sformatf("raw_rd_t%0d", t + 1),  int'(wb_rd),   e_rd[t]);
                check($sformatf("raw_dat_t%0d", t + 1), int'(wb_data), e_data[t]);
            end
        end

        // LDI then doubling chain with wraparound.
        for (int i = 0; i < 16; i++) prog[i] = '0;
        prog[0] = enc(6, 1, 7, 7);
        prog[1] = enc(1, 2, 1, 1);
        prog[2] = enc(1, 3, 2, 2);
        prog[3] = enc(1, 4, 3, 3);
        prog[4] = enc(15, 0, 0, 0);
        start_test();
        tick(20);
        run = 1'b0;
        tick(2);
        exp_q.push_back({3'd1, 8'd63});
        exp_q.push_back({3'd2, 8'd126});
        exp_q.push_back({3'd3, 8'd252});
        exp_q.push_back({3'd4, 8'd248});
        compare_stream("chain", 1'b1);
        check("chain_halted", int'(halted), 1);

        // HALT squashes the following instruction and is sticky.
        for (int i = 0; i < 16; i++) prog[i] = '0;
        prog[0] = enc(1, 3, 1, 2);
        prog[1] = enc(15, 0, 0, 0);
        prog[2] = enc(1, 6, 1, 1);
        start_test();
        tick(4);
        check("halt_not_yet", int'(halted), 0);
        tick(1);
        check("halt_set", int'(halted), 1);
        check("halt_pc",  int'(pc_o),   2);
        run = 1'b0;
        tick(2);
        run = 1'b1;
        tick(6);
        check("halt_sticky",    int'(halted), 1);
        check("halt_pc_frozen", int'(pc_o),   2);
        run = 1'b0;
        tick(2);
        exp_q.push_back({3'd3, 8'd3});
        compare_stream("halt", 1'b1);

        // PC wrap, live imem write and a 5-cycle freeze.
        for (int i = 0; i < 16; i++) prog[i] = '0;
        start_test();
        act = 0;
        for (int t = 1; t <= 30; t++) begin
            tick(1);
            if (run) act++;
            check($sformatf("wrap_pc_t%0d", t), int'(pc_o), act % 16);
            if (!run) check($sformatf("wrap_frozen_wbv_t%0d", t), int'(wb_valid), 0);
            imem_we    = (t == 2);
            imem_addr  = 4'd0;
            imem_wdata = enc(1, 3, 1, 2);
            run        = !(t >= 6 && t < 11);
        end
        imem_we = 1'b0;
        run     = 1'b0;
        tick(2);
        exp_q.push_back({3'd3, 8'd3});
        compare_stream("wrap", 1'b1);

        // Reset while running, then confirm register re-initialisation.
        for (int i = 0; i < 16; i++) prog[i] = enc(6, 1 + i % 7, ((i + 40) >> 3) & 7, (i + 40) & 7);
        start_test();
        tick(10);
        check("midrun_wbv_before", int'(wb_valid), 1);
        #2 reset = 1'b1;
        #1 check_all_zero("midrun_reset");
        for (int i = 0; i < 16; i++) prog[i] = '0;
        for (int i = 0; i < 8; i++)  prog[i] = enc(7, i, i, 0);
        prog[8] = enc(15, 0, 0, 0);
        start_test();
        tick(20);
        run = 1'b0;
        tick(2);
        for (int i = 0; i < 8; i++) exp_q.push_back({i[2:0], i[7:0]});
        compare_stream("reinit", 1'b1);

        // Randomized programs with random run gaps.
        for (int trial = 0; trial < 20; trial++) begin
            for (int i = 0; i < 16; i++) begin
                op = $urandom_range(0, 8);
                if (op == 8) op = $urandom_range(8, 14);
                prog[i] = enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            end
            if ($urandom_range(0, 1) == 1) prog[$urandom_range(3, 15)] = enc(15, 0, 0, 0);
            start_test();
            model_run(400);
            for (int t = 0; t < 160; t++) begin
                tick(1);
                run = ($urandom_range(0, 3) != 0);
            end
            run = 1'b0;
            tick(2);
            check($sformatf("rnd%0d_halted", trial), int'(halted), int'(exp_halt));
            if (exp_halt) begin
                check($sformatf("rnd%0d_halt_pc", trial), int'(pc_o), exp_halt_pc);
                compare_stream($sformatf("rnd%0d", trial), 1'b1);
            end else begin
                compare_stream($sformatf("rnd%0d", trial), 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
